// File: rtl/arb_client_pkg.sv
// Shared types and parameter defaults for the arbiter client.
package arb_client_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int DATA_W_DEF     = 8;
  localparam int DEPTH_DEF      = 4;
  localparam int WAIT_LIMIT_DEF = 31;

endpackage

// File: rtl/arb_client_fifo.sv
// Job buffer for the arbiter client: power-of-two circular FIFO with occupancy count.
module arb_client_fifo
  import arb_client_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            data,
  output logic [DATA_W-1:0]            head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/arb_client_sva.sv
// Protocol assertions for the arbiter client, bound into every arb_client instance.
module arb_client_sva #(
  parameter int WAIT_LIMIT = 31,
  parameter bit FAIR_ARB   = 1'b0
) (
  input logic                              clock,
  input logic                              reset,
  input logic                              request,
  input logic                              grant,
  input logic                              out_valid,
  input logic [$clog2(WAIT_LIMIT+2)-1:0]   wait_count
);

  localparam int WC_W = $clog2(WAIT_LIMIT+2);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LIMIT);

  a_req_hold: assert property (@(posedge clock) disable iff (reset)
    request && !grant |=> request);

  // Only meaningful when the surrounding arbiter is known to be fair.
  generate
    if (FAIR_ARB) begin : g_fair
      a_bounded_wait: assert property (@(posedge clock) disable iff (reset)
        request && wait_count == WC_LAST |-> grant);
    end
  endgenerate

  c_late_issue: cover property (@(posedge clock) disable iff (reset)
    out_valid && $past(grant) && $past(wait_count) == WC_LAST);

endmodule

bind arb_client arb_client_sva #(.WAIT_LIMIT(WAIT_LIMIT)) u_sva (
  .clock      (clock),
  .reset      (reset),
  .request    (request),
  .grant      (grant),
  .out_valid  (out_valid),
  .wait_count (wait_count)
);

// File: rtl/arb_client.sv
// Arbiter client: buffers upstream jobs, requests a round-robin arbiter and issues one job per grant.
//   state | meaning
//   IDLE  | buffer empty, request low
//   REQ   | buffer holds jobs, request high until granted
module arb_client
  import arb_client_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              in_ready,
  output logic                              request,
  input  logic                              grant,
  output logic                              out_valid,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(WAIT_LIMIT+2)-1:0]   wait_count,
  output logic                              starve,
  output logic                              proto_err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int WC_W  = $clog2(WAIT_LIMIT+2);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_LIMIT);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(WAIT_LIMIT + 1);

  state_t             state;
  state_t             state_nxt;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_head;
  logic [CNT_W-1:0]   fifo_count;

  assign in_ready = !fifo_full;
  assign request  = (state == REQ);
  assign push     = in_valid && !fifo_full;
  assign pop      = request && grant && !fifo_empty;

  arb_client_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .data  (in_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (push) state_nxt = REQ;
      REQ:  if (pop && !push && fifo_count == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      wait_count <= '0;
      starve     <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) out_data <= fifo_head;
      if (request && !grant) begin
        if (wait_count != WC_MAX) wait_count <= wait_count + 1'b1;
      end else begin
        wait_count <= '0;
      end
      // Set on the same edge that takes wait_count to WAIT_LIMIT+1.
      if (request && !grant && wait_count == WC_LAST) starve <= 1'b1;
      if (grant && !request) proto_err <= 1'b1;
    end
  end

endmodule

// File: doc/arb_client.md
ARB_CLIENT -- requirements
Module: arb_client

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries (power of two, >=2).
REQ-003 SHALL have parameter WAIT_LIMIT, default 31, maximum request-to-grant wait (CLIENTS-1 of a 32-client arbiter).
REQ-004 SHALL have a single clock domain and an asynchronous, active-high reset.
REQ-005 SHALL have port: clock  input  1  rising-edge clock.
REQ-006 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port: in_valid  input  1  upstream job present.
REQ-008 SHALL have port: in_data  input  DATA_W  upstream job payload.
REQ-009 SHALL have port: in_ready  output  1  buffer can accept; high iff occupancy < DEPTH.
REQ-010 SHALL have port: request  output  1  request to the round-robin arbiter.
REQ-011 SHALL have port: grant  input  1  grant from the arbiter for this client.
REQ-012 SHALL have port: out_valid  output  1  job issued (one-cycle pulse).
REQ-013 SHALL have port: out_data  output  DATA_W  issued job payload.
REQ-014 SHALL have port: wait_count  output  $clog2(WAIT_LIMIT+2)  cycles the current request has waited.
REQ-015 SHALL have port: starve  output  1  sticky flag: wait exceeded WAIT_LIMIT.
REQ-016 SHALL have port: proto_err  output  1  sticky flag: grant received while request low.

Function
REQ-017 SHALL push in_data when in_valid && in_ready, in FIFO order.
REQ-018 SHALL use FSM states IDLE (empty, request=0) and REQ (non-empty, request=1), with request a registered-state decode and no combinational path from grant.
REQ-019 SHALL transition IDLE->REQ on a push; REQ->IDLE on a grant that pops the last entry with no same-cycle push; otherwise hold state.
REQ-020 SHALL hold request high every cycle from entering REQ until the granted cycle, with no deassertion while ungranted.
REQ-021 SHALL pop the head when request && grant and drive out_valid=1, out_data=head in the following cycle (latency 1).
REQ-022 SHALL perform a same-cycle push and pop with occupancy unchanged; in_ready on a full buffer stays low even when grant pops in that cycle.
REQ-023 SHALL keep request high after a pop while entries remain, so back-to-back grants issue one job per cycle.
REQ-024 SHALL ignore grant while request is low (no pop, no out_valid) and set proto_err.
REQ-025 SHALL increment wait_count each cycle request && !grant, saturating at WAIT_LIMIT+1, and clear it to 0 on grant or in IDLE.
REQ-026 SHALL set starve when wait_count reaches WAIT_LIMIT+1, i.e. no grant within cycles 0..WAIT_LIMIT after request rose.
REQ-027 SHALL wrap read/write pointers modulo DEPTH, with an occupancy counter of width $clog2(DEPTH+1).
REQ-028 SHALL hold out_data stable between out_valid pulses.

Reset
REQ-029 SHALL force on reset, asynchronously: state=IDLE, occupancy=0, pointers=0, request=0, out_valid=0, out_data=0, wait_count=0, starve=0, proto_err=0, in_ready=1.
REQ-030 SHALL discard buffered jobs when reset is asserted mid-operation and produce no out_valid in the cycle after reset deasserts.
REQ-031 SHALL clear starve and proto_err only by reset.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, REQ) and the parameter defaults in a shared package arb_client_pkg.
REQ-033 SHALL implement buffering in one sub-module arb_client_fifo (push/pop/full/empty/head), with the FSM, wait counter and flags in arb_client.

Verification
REQ-034 SHALL pass: push 0xA5 with grant tied 0 for 32 cycles -> request high throughout, wait_count=32 and starve=1 at cycle 32, no out_valid.
REQ-035 SHALL pass: push 0x11,0x22,0x33 back-to-back, then grant held 3 cycles -> out_data 0x11,0x22,0x33 on consecutive cycles, request low after the third.
REQ-036 SHALL pass: fill 4 entries -> in_ready=0; grant plus in_valid in one cycle -> no push, occupancy 3, in_ready=1 next cycle.
REQ-037 SHALL pass: grant pulse while empty -> proto_err=1, out_valid=0, state IDLE.
REQ-038 SHALL pass: reset with 2 entries buffered and wait_count=5 -> all outputs at reset values, request=0 after release.
REQ-039 SHALL bind assertions: request && !grant |=> request; request |-> ##[0:WAIT_LIMIT] grant under a fair-arbiter assumption; plus a cover of out_valid after exactly WAIT_LIMIT wait cycles.
